// File: rtl/seq_match_monitor_pkg.sv
// Shared types and constants for the 1010 match-rate monitor.
// Holds the FSM state encoding and default widths.
package seq_match_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;
  localparam int DROP_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky
// overflow flag; exposes next-state values for same-edge capture.
module sat_counter
  import seq_match_monitor_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_sat,
  output logic [W-1:0] o_count_nxt,
  output logic         o_sat_nxt
);

  logic w_full;
  assign w_full = &o_count;

  always_comb begin
    o_count_nxt = o_count;
    o_sat_nxt   = o_sat;
    if (i_clr) begin
      o_count_nxt = '0;
      o_sat_nxt   = 1'b0;
    end else if (i_inc) begin
      // a hit landing on an already-full counter marks overflow
      if (w_full) o_sat_nxt = 1'b1;
      else o_count_nxt = o_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_count <= '0;
      o_sat   <= 1'b0;
    end else begin
      o_count <= o_count_nxt;
      o_sat   <= o_sat_nxt;
    end
  end

endmodule

// File: rtl/seq_match_monitor.sv
// Windowed hit counter with valid/ready report and threshold irq.
// SEQ_MATCH_MONITOR_DROP_CNT_EN adds the drop_count output.
module seq_match_monitor
  import seq_match_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] threshold,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_sat,
  output logic             irq
`ifdef SEQ_MATCH_MONITOR_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] drop_count
`endif
);

  state_e           r_state;
  logic [WIN_W-1:0] r_win_rem;
  logic [WIN_W-1:0] w_reload;
  logic [CNT_W-1:0] w_hit_cnt;
  logic [CNT_W-1:0] w_hit_nxt;
  logic             w_hit_sat;
  logic             w_sat_nxt;
  logic             w_unused_hit;

  assign w_reload = (win_len == '0) ? WIN_W'(1) : win_len;

  // held clear outside COUNT so each window starts from zero
  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state != COUNT),
    .i_inc       (r_state == COUNT && hit_in),
    .o_count     (w_hit_cnt),
    .o_sat       (w_hit_sat),
    .o_count_nxt (w_hit_nxt),
    .o_sat_nxt   (w_sat_nxt)
  );

  assign w_unused_hit = &{1'b0, w_hit_cnt, w_hit_sat};

`ifdef SEQ_MATCH_MONITOR_DROP_CNT_EN
  logic              w_drop_sat;
  logic [DROP_W-1:0] w_drop_nxt;
  logic              w_drop_sat_nxt;
  logic              w_unused_drop;

  sat_counter #(.W(DROP_W)) u_drop_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (1'b0),
    .i_inc       (r_state == REPORT && hit_in),
    .o_count     (drop_count),
    .o_sat       (w_drop_sat),
    .o_count_nxt (w_drop_nxt),
    .o_sat_nxt   (w_drop_sat_nxt)
  );

  assign w_unused_drop = &{1'b0, w_drop_sat, w_drop_nxt, w_drop_sat_nxt};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_win_rem <= '0;
      rpt_valid <= 1'b0;
      rpt_count <= '0;
      rpt_sat   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (enable) begin
            r_win_rem <= w_reload;
            r_state   <= COUNT;
          end
        end
        COUNT: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (r_win_rem == WIN_W'(1)) begin
            rpt_count <= w_hit_nxt;
            rpt_sat   <= w_sat_nxt;
            rpt_valid <= 1'b1;
            irq       <= (w_hit_nxt >= threshold);
            r_state   <= REPORT;
          end else begin
            r_win_rem <= r_win_rem - 1'b1;
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            rpt_valid <= 1'b0;
            if (enable) begin
              r_win_rem <= w_reload;
              r_state   <= COUNT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Self-checking bench for seq_match_monitor with a 4-bit hit counter.
// Reference model tracks raw hit totals and saturates only at report time.
module tb_seq_match_monitor;

  localparam int CW = 4;
  localparam int WW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          hit_in;
  logic          enable;
  logic [WW-1:0] win_len;
  logic [CW-1:0] threshold;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [CW-1:0] rpt_count;
  logic          rpt_sat;
  logic          irq;
`ifdef SEQ_MATCH_MONITOR_DROP_CNT_EN
  logic [7:0]    drop_count;
`endif

  int n_tests;
  int n_fail;

  // reference model state
  int m_phase;
  int m_rem;
  int m_hits;
  int e_valid;
  int e_count;
  int e_sat;
  int e_irq;
  int e_drop;

  seq_match_monitor #(.CNT_W(CW), .WIN_W(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .hit_in    (hit_in),
    .enable    (enable),
    .win_len   (win_len),
    .threshold (threshold),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count),
    .rpt_sat   (rpt_sat),
    .irq       (irq)
`ifdef SEQ_MATCH_MONITOR_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_drop();
`ifdef SEQ_MATCH_MONITOR_DROP_CNT_EN
    return int'(drop_count);
`else
    return e_drop;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_rem   = 0;
    m_hits  = 0;
    e_valid = 0;
    e_count = 0;
    e_sat   = 0;
    e_irq   = 0;
    e_drop  = 0;
  endtask

  task automatic model_step(input int h, input int e, input int r);
    int fin;
    e_irq = 0;
    if (m_phase == 0) begin
      if (e != 0) begin
        m_rem   = (win_len == 0) ? 1 : int'(win_len);
        m_hits  = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (e == 0) begin
        m_phase = 0;
      end else begin
        m_hits += h;
        m_rem  -= 1;
        if (m_rem == 0) begin
          fin     = (m_hits > CMAX) ? CMAX : m_hits;
          e_count = fin;
          e_sat   = (m_hits > CMAX) ? 1 : 0;
          e_valid = 1;
          e_irq   = (fin >= int'(threshold)) ? 1 : 0;
          m_phase = 2;
        end
      end
    end else begin
      if (h != 0 && e_drop < 255) e_drop += 1;
      if (r != 0) begin
        e_valid = 0;
        if (e != 0) begin
          m_rem   = (win_len == 0) ? 1 : int'(win_len);
          m_hits  = 0;
          m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic tick(input logic h, input logic e, input logic r);
    hit_in    = h;
    enable    = e;
    rpt_ready = r;
    @(posedge clk);
    model_step(int'(h), int'(e), int'(r));
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hit_in = 1'b0;
    enable = 1'b0;
    rpt_ready = 1'b0;
    win_len = '0;
    threshold = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (rpt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %0b want 0", rpt_valid);
    end
    n_tests++;
    if (rpt_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", rpt_count);
    end
    n_tests++;
    if (rpt_sat !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sat_irq got %0b/%0b want 0/0", rpt_sat, irq);
    end
`ifdef SEQ_MATCH_MONITOR_DROP_CNT_EN
    n_tests++;
    if (drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_drop got %0d want 0", drop_count);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic run_window8(input int thr, input int want_irq);
    win_len = 16'd8;
    threshold = CW'(thr);
    tick(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick((k == 1 || k == 3 || k == 8), 1'b1, 1'b0);
      if (k == 7) begin
        n_tests++;
        if (rpt_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL win8_early_valid got %0b want 0", rpt_valid);
        end
      end
    end
    n_tests++;
    if (rpt_valid !== 1'b1 || rpt_count !== 4'd3) begin
      n_fail++;
      $display("FAIL win8_report valid %0b count %0d want 1/3", rpt_valid, rpt_count);
    end
    n_tests++;
    if (irq !== want_irq[0]) begin
      n_fail++;
      $display("FAIL win8_irq thr %0d got %0b want %0d", thr, irq, want_irq);
    end
    tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (rpt_valid !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL win8_consume valid %0b irq %0b want 0/0", rpt_valid, irq);
    end
  endtask

  task automatic test_window();
    run_window8(3, 1);
    run_window8(4, 0);
  endtask

  task automatic test_saturation();
    win_len = 16'd20;
    threshold = 4'd0;
    tick(1'b1, 1'b1, 1'b0);
    repeat (20) tick(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (rpt_valid !== 1'b1 || rpt_count !== 4'd15 || rpt_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_report v%0b c%0d s%0b want 1/15/1", rpt_valid, rpt_count, rpt_sat);
    end
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_irq_thr0 got %0b want 1", irq);
    end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int d0;
    win_len = 16'd4;
    threshold = 4'd1;
    tick(1'b0, 1'b1, 1'b0);
    repeat (4) tick(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (rpt_valid !== 1'b1 || rpt_count !== 4'd4 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first v%0b c%0d i%0b want 1/4/1", rpt_valid, rpt_count, irq);
    end
    d0 = exp_drop();
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      n_tests++;
      if (rpt_valid !== 1'b1 || rpt_count !== 4'd4 || rpt_sat !== 1'b0 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d v%0b c%0d s%0b i%0b want 1/4/0/0",
                 k, rpt_valid, rpt_count, rpt_sat, irq);
      end
    end
    tick(1'b0, 1'b0, 1'b1);
`ifdef SEQ_MATCH_MONITOR_DROP_CNT_EN
    n_tests++;
    if (int'(drop_count) - d0 != 5 || int'(drop_count) != e_drop) begin
      n_fail++;
      $display("FAIL bp_drop got %0d (start %0d) want +5 = %0d", drop_count, d0, e_drop);
    end
`else
    d0 = d0 + 0;
`endif
    n_tests++;
    if (rpt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got %0b want 0", rpt_valid);
    end
  endtask

  task automatic test_abort();
    win_len = 16'd6;
    threshold = 4'd0;
    tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    repeat (8) begin
      tick(1'b1, 1'b0, 1'b1);
      n_tests++;
      if (rpt_valid !== 1'b0 || irq !== 1'b0 || rpt_count !== 4'd4) begin
        n_fail++;
        $display("FAIL abort v%0b i%0b c%0d want 0/0/4", rpt_valid, irq, rpt_count);
      end
    end
  endtask

  task automatic test_zero_window();
    win_len = 16'd0;
    threshold = 4'd1;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (rpt_valid !== 1'b1 || rpt_count !== 4'd1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_win v%0b c%0d i%0b want 1/1/1", rpt_valid, rpt_count, irq);
    end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    win_len = 16'd5;
    threshold = 4'd2;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (rpt_valid !== 1'b0 || rpt_count !== 4'd0 || rpt_sat !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid v%0b c%0d s%0b i%0b want all 0",
               rpt_valid, rpt_count, rpt_sat, irq);
    end
`ifdef SEQ_MATCH_MONITOR_DROP_CNT_EN
    n_tests++;
    if (drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_drop got %0d want 0", drop_count);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) tick((k != 2), 1'b1, 1'b0);
    n_tests++;
    if (rpt_valid !== 1'b1 || rpt_count !== 4'd4 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_restart v%0b c%0d i%0b want 1/4/1", rpt_valid, rpt_count, irq);
    end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) win_len = WW'($urandom_range(0, 20));
      if ($urandom_range(0, 15) == 0) threshold = CW'($urandom_range(0, 15));
      tick(1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) != 0),
           1'($urandom_range(0, 1)));
      n_tests++;
      if (rpt_valid !== e_valid[0] || rpt_count !== CW'(e_count) ||
          rpt_sat !== e_sat[0] || irq !== e_irq[0]) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL rand_c%0d v%0b c%0d s%0b i%0b want %0d/%0d/%0d/%0d",
                   c, rpt_valid, rpt_count, rpt_sat, irq,
                   e_valid, e_count, e_sat, e_irq);
        errs++;
      end
`ifdef SEQ_MATCH_MONITOR_DROP_CNT_EN
      n_tests++;
      if (drop_count !== 8'(e_drop)) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL rand_drop_c%0d got %0d want %0d", c, drop_count, e_drop);
        errs++;
      end
`endif
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_window();
    test_saturation();
    test_backpressure();
    test_abort();
    test_zero_window();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
